// File: rtl/mem_wb_stage.sv
// MEM stage with internal synchronous word RAM and MEM/WB pipeline register.
// Optional misaligned-access detection is enabled by defining MEM_ALIGN_CHECK_EN.
module mem_wb_stage #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] in_alu_res,
    input  logic [DATA_W-1:0] in_write_data,
    input  logic              in_is_jump,
    input  logic              in_reg_wrenable,
    input  logic [4:0]        in_write_reg,
    input  logic              in_mem_wrenable,
    input  logic              in_mem_to_reg,
    input  logic              stall,
    input  logic              flush,
    output logic [DATA_W-1:0] out_wb_data,
    output logic [4:0]        out_write_reg,
    output logic              out_reg_wrenable,
    output logic              out_is_jump,
    output logic              fwd_valid,
    output logic [4:0]        fwd_reg,
    output logic [DATA_W-1:0] fwd_data,
    output logic              load_pending,
    output logic              out_fault,
    output logic [DATA_W-1:0] out_fault_addr
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] ram_q [DEPTH];
    logic [ADDR_W-1:0] word_idx;
    logic              misaligned;
    logic              advance;
    logic              ram_we;
    logic              dest_nonzero;

    logic [DATA_W-1:0] alu_q, alu_d;
    logic [DATA_W-1:0] rdata_q;
    logic              m2r_q, m2r_d;
    logic [4:0]        wreg_q, wreg_d;
    logic              wren_q, wren_d;
    logic              jump_q, jump_d;

    assign word_idx     = in_alu_res[ADDR_W+1:2];
    assign dest_nonzero = (in_write_reg != 5'd0);

`ifdef MEM_ALIGN_CHECK_EN
    assign misaligned = (in_mem_wrenable || in_mem_to_reg) && (in_alu_res[1:0] != 2'b00);
`else
    assign misaligned = 1'b0;
`endif

    assign advance = rst_n && !flush && !stall;
    assign ram_we  = advance && in_mem_wrenable && !misaligned;

    // RAM contents survive reset; only the pipeline registers are cleared.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            ram_q[word_idx] <= in_write_data;
        end
    end

    // Read-first: the registered word is the value before this edge's store.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else if (!flush && !stall) begin
            rdata_q <= ram_q[word_idx];
        end
    end

    always_comb begin
        alu_d  = alu_q;
        m2r_d  = m2r_q;
        wreg_d = wreg_q;
        wren_d = wren_q;
        jump_d = jump_q;
        if (flush) begin
            wren_d = 1'b0;
            jump_d = 1'b0;
        end else if (!stall) begin
            alu_d  = in_alu_res;
            m2r_d  = in_mem_to_reg;
            wreg_d = in_write_reg;
            wren_d = in_reg_wrenable && dest_nonzero && !misaligned;
            jump_d = in_is_jump;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            alu_q  <= '0;
            m2r_q  <= 1'b0;
            wreg_q <= 5'd0;
            wren_q <= 1'b0;
            jump_q <= 1'b0;
        end else begin
            alu_q  <= alu_d;
            m2r_q  <= m2r_d;
            wreg_q <= wreg_d;
            wren_q <= wren_d;
            jump_q <= jump_d;
        end
    end

`ifdef MEM_ALIGN_CHECK_EN
    logic              fault_q, fault_d;
    logic [DATA_W-1:0] fault_addr_q, fault_addr_d;

    // A flushed instruction never retires, so it neither faults nor updates the address.
    always_comb begin
        fault_d      = fault_q;
        fault_addr_d = fault_addr_q;
        if (flush) begin
            fault_d = 1'b0;
        end else if (!stall) begin
            fault_d = misaligned;
            if (misaligned) begin
                fault_addr_d = in_alu_res;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fault_q      <= 1'b0;
            fault_addr_q <= '0;
        end else begin
            fault_q      <= fault_d;
            fault_addr_q <= fault_addr_d;
        end
    end

    assign out_fault      = fault_q;
    assign out_fault_addr = fault_addr_q;
`else
    assign out_fault      = 1'b0;
    assign out_fault_addr = '0;
`endif

    assign out_wb_data      = m2r_q ? rdata_q : alu_q;
    assign out_write_reg    = wreg_q;
    assign out_reg_wrenable = wren_q;
    assign out_is_jump      = jump_q;

    assign fwd_valid    = in_reg_wrenable && !in_mem_to_reg && dest_nonzero && !flush;
    assign fwd_reg      = in_write_reg;
    assign fwd_data     = in_alu_res;
    assign load_pending = in_reg_wrenable && in_mem_to_reg && dest_nonzero && !flush;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage: the driver pushes hand-computed write-back
// expectations, a monitor pops and compares them one cycle after issue.
module tb_mem_wb_stage;

    localparam int W = 73;  // {fault_addr, wb_data, write_reg, wren, jump, fault, check_wb}

    logic        clk;
    logic        rst_n;
    logic [31:0] in_alu_res;
    logic [31:0] in_write_data;
    logic        in_is_jump;
    logic        in_reg_wrenable;
    logic [4:0]  in_write_reg;
    logic        in_mem_wrenable;
    logic        in_mem_to_reg;
    logic        stall;
    logic        flush;
    logic [31:0] out_wb_data;
    logic [4:0]  out_write_reg;
    logic        out_reg_wrenable;
    logic        out_is_jump;
    logic        fwd_valid;
    logic [4:0]  fwd_reg;
    logic [31:0] fwd_data;
    logic        load_pending;
    logic        out_fault;
    logic [31:0] out_fault_addr;

    logic [W-1:0] exp_q[$];
    logic         chk;
    logic [31:0]  fa_exp;
    int           checks;
    int           errors;

    mem_wb_stage #(.ADDR_W(10), .DATA_W(32)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .in_alu_res       (in_alu_res),
        .in_write_data    (in_write_data),
        .in_is_jump       (in_is_jump),
        .in_reg_wrenable  (in_reg_wrenable),
        .in_write_reg     (in_write_reg),
        .in_mem_wrenable  (in_mem_wrenable),
        .in_mem_to_reg    (in_mem_to_reg),
        .stall            (stall),
        .flush            (flush),
        .out_wb_data      (out_wb_data),
        .out_write_reg    (out_write_reg),
        .out_reg_wrenable (out_reg_wrenable),
        .out_is_jump      (out_is_jump),
        .fwd_valid        (fwd_valid),
        .fwd_reg          (fwd_reg),
        .fwd_data         (fwd_data),
        .load_pending     (load_pending),
        .out_fault        (out_fault),
        .out_fault_addr   (out_fault_addr)
    );

    // clock/reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
        end
    endtask

    // driver tasks
    task automatic op(input logic [31:0] alu, input logic [31:0] wd, input logic j,
                      input logic rwe, input logic [4:0] wr, input logic mwe, input logic m2r,
                      input logic st, input logic fl,
                      input logic [31:0] ewb, input logic [4:0] ereg, input logic ewe,
                      input logic ej, input logic ef, input logic ecw);
        in_alu_res      = alu;
        in_write_data   = wd;
        in_is_jump      = j;
        in_reg_wrenable = rwe;
        in_write_reg    = wr;
        in_mem_wrenable = mwe;
        in_mem_to_reg   = m2r;
        stall           = st;
        flush           = fl;
        exp_q.push_back({fa_exp, ewb, ereg, ewe, ej, ef, ecw});
        chk = 1'b1;
    endtask

    task automatic fwd_chk(input logic v, input logic [4:0] r, input logic [31:0] d, input logic lp);
        #1;
        cmp("fwd_valid", {31'd0, fwd_valid}, {31'd0, v});
        cmp("fwd_reg", {27'd0, fwd_reg}, {27'd0, r});
        cmp("fwd_data", fwd_data, d);
        cmp("load_pending", {31'd0, load_pending}, {31'd0, lp});
    endtask

    task automatic nxt();
        @(negedge clk);
    endtask

    // scoreboard monitor: pops one expectation per issued cycle, #1 after the edge
    always @(posedge clk) begin
        logic         pend;
        logic [W-1:0] e;
        pend = chk;
        #1;
        if (pend) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL scoreboard_underflow actual=empty expected=entry");
            end else begin
                e = exp_q.pop_front();
                if (e[0]) begin
                    cmp("out_wb_data", out_wb_data, e[40:9]);
                    cmp("out_write_reg", {27'd0, out_write_reg}, {27'd0, e[8:4]});
                end
                cmp("out_reg_wrenable", {31'd0, out_reg_wrenable}, {31'd0, e[3]});
                cmp("out_is_jump", {31'd0, out_is_jump}, {31'd0, e[2]});
                cmp("out_fault", {31'd0, out_fault}, {31'd0, e[1]});
                cmp("out_fault_addr", out_fault_addr, e[72:41]);
            end
        end
    end

    initial begin
        checks = 0;
        errors = 0;
        chk    = 1'b0;
        fa_exp = 32'h0;
        rst_n  = 1'b0;
        op(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        exp_q.delete();
        chk = 1'b0;
        nxt();

        // reset with random inputs: everything must read back as zero
        repeat (2) begin
            op($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
            nxt();
        end
        rst_n = 1'b1;

        // store, then loads including an aliased (wrapped) address
        op(32'h40, 32'hDEADBEEF, 0, 0, 0, 1, 0, 0, 0, 32'h40, 0, 0, 0, 0, 1); nxt();
        op(32'h40, 32'h0, 0, 1, 5, 0, 1, 0, 0, 32'hDEADBEEF, 5, 1, 0, 0, 1);
        fwd_chk(0, 5, 32'h40, 1); nxt();
        op(32'h1040, 32'h0, 0, 1, 6, 0, 1, 0, 0, 32'hDEADBEEF, 6, 1, 0, 0, 1); nxt();

        // ALU results, r0 drop, jump link
        op(32'h1234, 32'h0, 0, 1, 7, 0, 0, 0, 0, 32'h1234, 7, 1, 0, 0, 1);
        fwd_chk(1, 7, 32'h1234, 0); nxt();
        op(32'h5678, 32'h0, 0, 1, 0, 0, 0, 0, 0, 32'h5678, 0, 0, 0, 0, 1);
        fwd_chk(0, 0, 32'h5678, 0); nxt();
        op(32'h100, 32'h0, 1, 1, 31, 0, 0, 0, 0, 32'h100, 31, 1, 1, 0, 1); nxt();

        // stall 3 cycles during a store: outputs frozen on the jump result
        repeat (3) begin
            op(32'h80, 32'h55, 0, 0, 0, 1, 0, 1, 0, 32'h100, 31, 1, 1, 0, 1); nxt();
        end
        op(32'h80, 32'h55, 0, 0, 0, 1, 0, 0, 0, 32'h80, 0, 0, 0, 0, 1); nxt();

        // a stalled store that is then flushed must never reach RAM
        op(32'h84, 32'h77, 0, 0, 0, 1, 0, 0, 0, 32'h84, 0, 0, 0, 0, 1); nxt();
        repeat (2) begin
            op(32'h84, 32'hAA, 0, 0, 0, 1, 0, 1, 0, 32'h84, 0, 0, 0, 0, 1); nxt();
        end
        op(32'h84, 32'hAA, 0, 0, 0, 1, 0, 0, 1, 32'h0, 0, 0, 0, 0, 0); nxt();
        op(32'h84, 32'h0, 0, 1, 3, 0, 1, 0, 0, 32'h77, 3, 1, 0, 0, 1);
        fwd_chk(0, 3, 32'h84, 1); nxt();
        op(32'h80, 32'h0, 0, 1, 1, 0, 1, 0, 0, 32'h55, 1, 1, 0, 0, 1); nxt();

        // flush squashes store, reg write and jump
        op(32'h10, 32'h0A, 0, 0, 0, 1, 0, 0, 0, 32'h10, 0, 0, 0, 0, 1); nxt();
        op(32'h10, 32'h99, 1, 1, 9, 1, 0, 0, 1, 32'h0, 0, 0, 0, 0, 0);
        fwd_chk(0, 9, 32'h10, 0); nxt();
        op(32'h10, 32'h0, 0, 1, 2, 0, 1, 0, 0, 32'h0A, 2, 1, 0, 0, 1); nxt();

        // flush and stall together: flush wins
        op(32'h10, 32'hBB, 1, 1, 4, 1, 0, 1, 1, 32'h0, 0, 0, 0, 0, 0); nxt();
        op(32'h10, 32'h0, 0, 1, 2, 0, 1, 0, 0, 32'h0A, 2, 1, 0, 0, 1); nxt();

        // load and store in one instruction: read-first, then new data visible
        op(32'h40, 32'hCAFEF00D, 0, 1, 8, 1, 1, 0, 0, 32'hDEADBEEF, 8, 1, 0, 0, 1);
        fwd_chk(0, 8, 32'h40, 1); nxt();
        op(32'h40, 32'h0, 0, 1, 8, 0, 1, 0, 0, 32'hCAFEF00D, 8, 1, 0, 0, 1); nxt();

        // misaligned store to 0x42
`ifdef MEM_ALIGN_CHECK_EN
        fa_exp = 32'h42;
        op(32'h42, 32'h3, 0, 1, 11, 1, 0, 0, 0, 32'h42, 11, 0, 0, 1, 1); nxt();
        op(32'h40, 32'h0, 0, 1, 10, 0, 1, 0, 0, 32'hCAFEF00D, 10, 1, 0, 0, 1); nxt();
`else
        op(32'h42, 32'h3, 0, 1, 11, 1, 0, 0, 0, 32'h42, 11, 1, 0, 0, 1); nxt();
        op(32'h40, 32'h0, 0, 1, 10, 0, 1, 0, 0, 32'h3, 10, 1, 0, 0, 1); nxt();
`endif

        op(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        chk = 1'b0;
        void'(exp_q.pop_back());
        nxt();
        nxt();
        cmp("scoreboard_drained", exp_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // watchdog
    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- Memory-access stage plus MEM/WB pipeline register.
- Consumes the EX/MEM register outputs: ALU result, store data and control bits.
- Performs word loads and stores against an internal synchronous data RAM.
- Registers the write-back fields for the register file one cycle later.
- Also provides the MEM-stage forwarding/hazard view to the hazard unit.

Parameters:
ADDR_W, 10, word-address width; RAM depth = 2^ADDR_W 32-bit words
DATA_W, 32, datapath width (only 32 supported)

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  synchronous active-low reset
in_alu_res  in  32  byte address for loads/stores; result value otherwise
in_write_data  in  32  store data
in_is_jump  in  1  instruction is a jump
in_reg_wrenable  in  1  instruction writes the register file
in_write_reg  in  5  destination register
in_mem_wrenable  in  1  store
in_mem_to_reg  in  1  load
stall  in  1  hold MEM/WB contents; suppress the store
flush  in  1  squash the instruction currently in MEM
out_wb_data  out  32  write-back value
out_write_reg  out  5  registered destination
out_reg_wrenable  out  1  registered write enable
out_is_jump  out  1  registered jump flag
fwd_valid  out  1  MEM-stage result forwardable this cycle
fwd_reg  out  5  MEM-stage destination
fwd_data  out  32  MEM-stage forwardable value (= in_alu_res)
load_pending  out  1  load in MEM with a nonzero destination (load-use hazard)
out_fault  out  1  misaligned access retired (optional feature)
out_fault_addr  out  32  sticky address of last misaligned access

Behaviour:
- Clock and reset: one clock clk. rst_n is synchronous and active-low.
- Reset values: out_reg_wrenable=0, out_is_jump=0, out_write_reg=0, internal alu/rdata/mem_to_reg regs=0 (so out_wb_data=0), out_fault=0, out_fault_addr=0.
- Reset does not clear RAM contents.
- Word index: in_alu_res[ADDR_W+1:2]. Higher address bits are ignored, so addresses wrap modulo the RAM size.
- Store: RAM word is written at posedge when in_mem_wrenable=1, stall=0, flush=0 and rst_n=1.
- Load: RAM is read synchronously at the same posedge and the data is registered. Read-first: a load and a store in the same instruction return the old word.
- Latency: every out_* reflects the MEM-stage instruction one cycle later.
- Back-to-back store then load to the same address: the load returns the new data.
- out_wb_data = registered mem_to_reg ? registered RAM data : registered alu_res. This is combinational from registers.
- out_reg_wrenable is registered as in_reg_wrenable && (in_write_reg != 0); writes to r0 are dropped.
- Priority at posedge: reset > flush > stall > normal.
  - flush=1: out_reg_wrenable<=0, out_is_jump<=0, store suppressed, out_fault<=0. Other fields don't-care.
  - stall=1 (flush=0): all out_* and internal registers hold, RAM is not written, registered read data holds. A stall held for N cycles holds for N cycles.
  - stall=0 and flush=0: registers load normally.
- Forwarding (combinational from inputs):
  - fwd_valid = in_reg_wrenable && !in_mem_to_reg && in_write_reg!=0 && !flush.
  - fwd_reg = in_write_reg.
  - fwd_data = in_alu_res.
  - load_pending = in_reg_wrenable && in_mem_to_reg && in_write_reg!=0 && !flush.
- Jumps pass through. The link value arrives in in_alu_res and is written back like any ALU result.

Optional Feature:
- Macro: MEM_ALIGN_CHECK_EN.
- Defined: a load or store with in_alu_res[1:0]!=0 is misaligned. For a misaligned access:
  - The store is suppressed.
  - The registered out_reg_wrenable is 0.
  - out_fault pulses 1 for exactly one cycle, aligned with the write-back of that instruction.
  - out_fault_addr captures in_alu_res and holds it until the next fault or reset.
  - Stall holds out_fault at its value; flush clears it.
- Not defined: in_alu_res[1:0] is ignored (word access to the truncated address), out_fault is tied 0 and out_fault_addr is tied 0.

Test Plan:
- Reset: drive rst_n=0 for 2 cycles with random inputs -> out_reg_wrenable=0, out_is_jump=0, out_wb_data=0. After release, the first instruction appears one cycle after it is presented.
- Store/load: store 0xDEADBEEF to 0x40, next cycle load 0x40 into r5 -> one cycle later out_wb_data=0xDEADBEEF, out_write_reg=5, out_reg_wrenable=1. Load 0x40+(4<<ADDR_W) -> same data (wrap).
- ALU/forward: in_alu_res=0x1234, reg 7, no mem -> fwd_valid=1, fwd_reg=7, fwd_data=0x1234 in the same cycle. Next cycle out_wb_data=0x1234. With write_reg=0 -> fwd_valid=0, out_reg_wrenable=0. A load to r3 -> load_pending=1, fwd_valid=0.
- Stall: hold stall=1 for 3 cycles during a store of 0x55 to 0x80 -> outputs frozen and RAM unchanged. Release -> store commits once and a later load from 0x80 returns 0x55.
- Flush: flush=1 with a store of 0x99 to 0x10 and reg write to r9 -> RAM[0x10] unchanged, next-cycle out_reg_wrenable=0, out_is_jump=0. Flush and stall together -> flush wins.
- Alignment (MEM_ALIGN_CHECK_EN): store to 0x42 -> RAM unchanged, out_fault=1 for one cycle, out_fault_addr=0x42. Without the macro -> word 0x40 is written and out_fault=0.
